wspr_config_loader: RTL and testbench
=====================================

// Module: wspr_config_loader
// PURPOSE
//  Receiving end of the byte-wide configuration interface that the host drives with
//  io_config_start / io_config_bits_in / io_config_valid_in.
//  Parses a fixed 21-byte record into WSPR message fields and radio timing/frequency
//  words, and range-checks each field. Presents them, registered, to the encoder and
//  RF NCO, with a ready flag and an error flag.
// PARAMETERS
//  NUM_BYTES  21  record length: 6 call + 4 grid + 1 power + 4 + 4 + 2
//  MAX_DBM    60  largest legal power byte
// PORTS
//  clock              in   1   system clock, all state on rising edge
//  reset              in   1   asynchronous, active-low; clears all state
//  io_config_start    in   1   level; while high, loader is cleared and armed
//  io_config_bits_in  in   8   record byte
//  io_config_valid_in in   1   one-cycle strobe; byte accepted on this edge
//  io_call            out  36  6 chars x 6b char codes, char0 in [35:30]
//  io_grid            out  24  4 chars x 6b char codes, char0 in [23:18]
//  io_power           out  6   dBm, 0..MAX_DBM
//  io_sym_period      out  32  clock cycles per WSPR symbol (bytes 11-14, MSB first)
//  io_base_ftw        out  32  NCO base tuning word (bytes 15-18, MSB first)
//  io_tone_step       out  16  FTW increment per tone (bytes 19-20, MSB first)
//  io_cfg_ready       out  1   record complete and error-free
//  io_cfg_error       out  1   sticky: illegal char/power, or overrun
//  io_byte_count      out  5   bytes accepted since arm, saturates at NUM_BYTES
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE.
//  - States: IDLE -> ARM -> LOAD -> DONE.
//    - IDLE: ignore valid; start=1 -> ARM.
//    - ARM (start high): clear fields, count, ready and error; start=0 -> LOAD.
//    - LOAD: each valid strobe stores a byte at index count, then count++.
//      Count reaching NUM_BYTES -> DONE.
//    - DONE: ready = !error. A further valid sets error, clears ready, holds data.
//  - Start high from any state -> ARM next cycle; a record in progress is discarded.
//  - Valid is ignored in IDLE and in ARM, including valid together with start.
//  - Char code (byte index 0-9):
//    - '0'-'9' -> 0-9; 'A'-'Z' -> 10-35; 'a'-'z' folds to upper case; ' ' -> 36.
//    - Any other byte: store 63 and set error.
//  - Power (byte index 10): value > MAX_DBM stores MAX_DBM and sets error.
//  - Multi-byte words shift in MSB first; each output word is updated as its bytes arrive.
//  - Latency: a byte strobed on edge N appears on its output after edge N.
//    io_cfg_ready rises the same edge the 21st byte is stored.
//  - io_cfg_error is sticky until the next ARM or reset.
//  - Bytes may be spaced arbitrarily; there is no timeout.
//  - Back-to-back valid on consecutive cycles is supported.
//  - Async reset mid-record returns to IDLE with all outputs 0.
// STRUCTURE
//  - Package wspr_cfg_pkg holds:
//    - state enum;
//    - byte-index constants CALL_LO=0, GRID_LO=6, PWR_IDX=10, SYM_LO=11, FTW_LO=15, STEP_LO=19;
//    - CHAR_SPACE=36 and CHAR_BAD=63;
//    - function ascii_to_wspr (8b -> 6b code + bad flag).
//  - Sub-module wspr_char_encode wraps ascii_to_wspr; one instance, combinational.
//    Everything else is flat: FSM, byte counter, field registers.
// TESTING
//  1. Load " K3RTL","FN20",13, then 00 01 86 A0, 64 01 A3 6E, 53 E3, bytes 2000 cycles apart
//     -> call=36,20,3,27,29,21; grid=15,23,2,0; power=13; sym_period=0x000186A0;
//     base_ftw=0x6401A36E; tone_step=0x53E3; ready=1, error=0.
//  2. Same record, valid on 21 consecutive cycles -> identical fields;
//     ready rises on the edge storing byte 20.
//  3. Byte 2 = '#' -> call char2 = 63, error=1; after 21 bytes ready=0.
//     Re-arm with start -> error=0, count=0.
//  4. Power byte 61 -> power=60, error=1. Record complete -> 22nd byte 0x55 -> data unchanged.
//  5. Start pulsed after 9 bytes -> count=0, fields 0; then a full record loads correctly.
//     Valid asserted while start high -> ignored.
//  6. Assert reset at byte 15 -> all outputs 0 asynchronously.
//     Valid after release, with no start -> ignored, count stays 0.

Source files
------------

// File: rtl/wspr_cfg_pkg.sv
// wspr_cfg_pkg: shared states, record layout and ASCII-to-WSPR character mapping.
package wspr_cfg_pkg;
  typedef enum logic [1:0] {IDLE, ARM, LOAD, DONE} state_t;
  localparam logic [4:0] CALL_LO = 5'd0;
  localparam logic [4:0] GRID_LO = 5'd6;
  localparam logic [4:0] PWR_IDX = 5'd10;
  localparam logic [4:0] SYM_LO = 5'd11;
  localparam logic [4:0] FTW_LO = 5'd15;
  localparam logic [4:0] STEP_LO = 5'd19;
  localparam logic [5:0] CHAR_SPACE = 6'd36;
  localparam logic [5:0] CHAR_BAD = 6'd63;
  // Returns {bad, code}; lower case folds onto upper case before mapping.
  function automatic logic [6:0] ascii_to_wspr(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'd32 : c;
    return (u >= 8'h30 && u <= 8'h39) ? {1'b0, 6'(u - 8'd48)} :
           (u >= 8'h41 && u <= 8'h5a) ? {1'b0, 6'(u - 8'd55)} :
           (u == 8'h20) ? {1'b0, CHAR_SPACE} : {1'b1, CHAR_BAD};
  endfunction
endpackage

// File: rtl/wspr_config_loader_if.sv
// wspr_config_loader_if: host byte stream in, parsed WSPR/radio fields out.
interface wspr_config_loader_if;
  logic        start;
  logic        valid;
  logic [7:0]  data;
  logic [35:0] call;
  logic [23:0] grid;
  logic [5:0]  power;
  logic [31:0] sym_period;
  logic [31:0] base_ftw;
  logic [15:0] tone_step;
  logic        cfg_ready;
  logic        cfg_error;
  logic [4:0]  byte_count;
  modport master(output start, valid, data,
                 input call, grid, power, sym_period, base_ftw, tone_step, cfg_ready, cfg_error, byte_count);
  modport slave(input start, valid, data,
                output call, grid, power, sym_period, base_ftw, tone_step, cfg_ready, cfg_error, byte_count);
endinterface

// File: rtl/wspr_char_encode.sv
// wspr_char_encode: combinational ASCII to 6-bit WSPR character code.
module wspr_char_encode
  import wspr_cfg_pkg::*;
(
  input  logic [7:0] ch,
  output logic [5:0] code,
  output logic       bad
);
  assign {bad, code} = ascii_to_wspr(ch);
endmodule

// File: rtl/wspr_config_loader.sv
// wspr_config_loader: parses the 21-byte host config record into range-checked WSPR fields.
module wspr_config_loader
  import wspr_cfg_pkg::*;
#(
  parameter int NUM_BYTES = 21,
  parameter int MAX_DBM   = 60
) (
  input logic clock,
  input logic reset,
  wspr_config_loader_if.slave cfg
);
  state_t state, state_nx;
  logic [5:0] code;
  logic bad, take, last, field_err;
  logic [4:0] idx;
  wspr_char_encode u_enc (.ch(cfg.data), .code(code), .bad(bad));
  assign idx = cfg.byte_count;
  assign take = state == LOAD && cfg.valid && !cfg.start;
  assign last = idx == 5'(NUM_BYTES - 1);
  assign field_err = (idx < PWR_IDX && bad) || (idx == PWR_IDX && cfg.data > 8'(MAX_DBM));
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = cfg.start ? ARM : state == ARM ? LOAD : (take && last) ? DONE : state;
  end
  // ARM holds every field cleared so a discarded record leaves no residue.
  always_ff @(posedge clock or negedge reset)
    if (!reset || state == ARM) begin
      cfg.call       <= '0;
      cfg.grid       <= '0;
      cfg.power      <= '0;
      cfg.sym_period <= '0;
      cfg.base_ftw   <= '0;
      cfg.tone_step  <= '0;
      cfg.cfg_ready  <= 1'b0;
      cfg.cfg_error  <= 1'b0;
      cfg.byte_count <= '0;
    end else if (take) begin
      cfg.byte_count <= idx + 5'd1;
      for (int i = 0; i < 6; i++)
        if (idx == 5'(CALL_LO + 5'(i))) cfg.call[35-6*i -: 6] <= code;
      for (int i = 0; i < 4; i++)
        if (idx == 5'(GRID_LO + 5'(i))) cfg.grid[23-6*i -: 6] <= code;
      if (idx == PWR_IDX) cfg.power <= cfg.data > 8'(MAX_DBM) ? 6'(MAX_DBM) : cfg.data[5:0];
      if (idx >= SYM_LO && idx < FTW_LO) cfg.sym_period <= {cfg.sym_period[23:0], cfg.data};
      if (idx >= FTW_LO && idx < STEP_LO) cfg.base_ftw <= {cfg.base_ftw[23:0], cfg.data};
      if (idx >= STEP_LO) cfg.tone_step <= {cfg.tone_step[7:0], cfg.data};
      cfg.cfg_error <= cfg.cfg_error | field_err;
      if (last) cfg.cfg_ready <= !(cfg.cfg_error | field_err);
    end else if (state == DONE && cfg.valid && !cfg.start) begin
      cfg.cfg_error <= 1'b1;
      cfg.cfg_ready <= 1'b0;
    end
endmodule

// File: tb/tb_wspr_config_loader.sv
// tb_wspr_config_loader: directed vectors with hand-computed expectations for the config loader.
module tb_wspr_config_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] rec [21];
  localparam logic [35:0] CALL_EXP = {6'd36, 6'd20, 6'd3, 6'd27, 6'd29, 6'd21};
  localparam logic [23:0] GRID_EXP = {6'd15, 6'd23, 6'd2, 6'd0};
  wspr_config_loader_if cfg ();
  wspr_config_loader dut (.clock(clk), .reset(rst_n), .cfg(cfg));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    cfg.data = b;
    cfg.valid = 1'b1;
    @(posedge clk);
    #1 cfg.valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arm();
    cfg.start = 1'b1;
    @(posedge clk);
    #1 cfg.start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int gap);
    for (int i = 0; i < 21; i++) send(rec[i], gap);
  endtask

  task automatic set_rec();
    rec = '{8'h20, 8'h4B, 8'h33, 8'h52, 8'h54, 8'h4C, 8'h46, 8'h4E, 8'h32, 8'h30, 8'd13,
            8'h00, 8'h01, 8'h86, 8'hA0, 8'h64, 8'h01, 8'hA3, 8'h6E, 8'h53, 8'hE3};
  endtask

  task automatic check_all(input string tag, input logic [35:0] c, input logic [5:0] p,
                           input logic rdy, input logic err);
    check({tag, ".call"}, 64'(cfg.call), 64'(c));
    check({tag, ".grid"}, 64'(cfg.grid), 64'(GRID_EXP));
    check({tag, ".power"}, 64'(cfg.power), 64'(p));
    check({tag, ".sym"}, 64'(cfg.sym_period), 64'h000186A0);
    check({tag, ".ftw"}, 64'(cfg.base_ftw), 64'h6401A36E);
    check({tag, ".step"}, 64'(cfg.tone_step), 64'h53E3);
    check({tag, ".ready"}, 64'(cfg.cfg_ready), 64'(rdy));
    check({tag, ".error"}, 64'(cfg.cfg_error), 64'(err));
    check({tag, ".count"}, 64'(cfg.byte_count), 64'd21);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".call"}, 64'(cfg.call), 64'd0);
    check({tag, ".grid"}, 64'(cfg.grid), 64'd0);
    check({tag, ".power"}, 64'(cfg.power), 64'd0);
    check({tag, ".sym"}, 64'(cfg.sym_period), 64'd0);
    check({tag, ".ftw"}, 64'(cfg.base_ftw), 64'd0);
    check({tag, ".step"}, 64'(cfg.tone_step), 64'd0);
    check({tag, ".ready"}, 64'(cfg.cfg_ready), 64'd0);
    check({tag, ".error"}, 64'(cfg.cfg_error), 64'd0);
    check({tag, ".count"}, 64'(cfg.byte_count), 64'd0);
  endtask

  initial begin
    cfg.start = 1'b0;
    cfg.valid = 1'b0;
    cfg.data = 8'h00;
    set_rec();
    repeat (3) @(posedge clk);
    #1 check_zero("rst");
    rst_n = 1'b1;
    send(8'h41, 1);
    check("idle_ignore", 64'(cfg.byte_count), 64'd0);

    arm();
    load(2000);
    check_all("t1", CALL_EXP, 6'd13, 1'b1, 1'b0);

    arm();
    check("t2.arm_count", 64'(cfg.byte_count), 64'd0);
    for (int i = 0; i < 21; i++) begin
      cfg.data = rec[i];
      cfg.valid = 1'b1;
      @(posedge clk);
      #1;
      if (i == 13) check("t2.sym_part", 64'(cfg.sym_period), 64'h000186);
      if (i == 19) check("t2.ready_pre", 64'(cfg.cfg_ready), 64'd0);
    end
    cfg.valid = 1'b0;
    check_all("t2", CALL_EXP, 6'd13, 1'b1, 1'b0);
    send(8'h55, 1);
    check_all("t2.overrun", CALL_EXP, 6'd13, 1'b0, 1'b1);

    arm();
    rec[2] = 8'h23;
    for (int i = 0; i < 3; i++) send(rec[i], 0);
    check("t3.char2", 64'(cfg.call), 64'({6'd36, 6'd20, 6'd63, 18'd0}));
    check("t3.err_early", 64'(cfg.cfg_error), 64'd1);
    for (int i = 3; i < 21; i++) send(rec[i], 0);
    check_all("t3", {6'd36, 6'd20, 6'd63, 6'd27, 6'd29, 6'd21}, 6'd13, 1'b0, 1'b1);
    arm();
    check("t3.rearm_err", 64'(cfg.cfg_error), 64'd0);
    check("t3.rearm_cnt", 64'(cfg.byte_count), 64'd0);

    set_rec();
    rec[10] = 8'd61;
    load(0);
    check_all("t4", CALL_EXP, 6'd60, 1'b0, 1'b1);
    send(8'h55, 0);
    check_all("t4.overrun", CALL_EXP, 6'd60, 1'b0, 1'b1);

    set_rec();
    arm();
    for (int i = 0; i < 9; i++) send(rec[i], 0);
    check("t5.mid_cnt", 64'(cfg.byte_count), 64'd9);
    cfg.start = 1'b1;
    cfg.valid = 1'b1;
    cfg.data = 8'h5A;
    @(posedge clk);
    #1 cfg.start = 1'b0;
    cfg.valid = 1'b0;
    @(posedge clk);
    #1 check_zero("t5.restart");
    rec[1] = 8'h6B;
    rec[4] = 8'h74;
    rec[6] = 8'h66;
    rec[7] = 8'h6E;
    load(1);
    check_all("t5", CALL_EXP, 6'd13, 1'b1, 1'b0);

    set_rec();
    arm();
    for (int i = 0; i < 15; i++) send(rec[i], 0);
    check("t6.pre_cnt", 64'(cfg.byte_count), 64'd15);
    #3 rst_n = 1'b0;
    #1 check_zero("t6.async");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(rec[0], 1);
    check_zero("t6.no_start");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
